// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: NRD-read / NWR-write register file with per-register pending bits.
// Optional feature macro REGFILE_BYPASS_EN: same-cycle write-through to the read ports.
module rf_multiport_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rR,
    output logic [NRD*XLEN-1:0] rD,
    output logic [NRD-1:0]      rBusy,
    input  logic [NWR-1:0]      wE,
    input  logic [NWR*AW-1:0]   wR,
    input  logic [NWR*XLEN-1:0] wD,
    input  logic                issE,
    input  logic [AW-1:0]       issR,
    output logic [NREG-1:0]     pend
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Next array contents: later write ports override earlier ones.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wE[j] && (wR[j*AW +: AW] != '0)) begin
                regs_d[wR[j*AW +: AW]] = wD[j*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Next pending vector: writebacks clear, a new issue sets last.
    always_comb begin
        pend_d = pend_q;
        for (int j = 0; j < NWR; j++) begin
            if (wE[j]) begin
                pend_d[wR[j*AW +: AW]] = 1'b0;
            end
        end
        if (issE && (issR != '0)) begin
            pend_d[issR] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Register array state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Combinational read ports, optionally forwarding in-flight writes.
    always_comb begin
        rD    = '0;
        rBusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rD[i*XLEN +: XLEN] = regs_q[rR[i*AW +: AW]];
            rBusy[i]           = pend_q[rR[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wE[j] && (wR[j*AW +: AW] == rR[i*AW +: AW])
                    && (rR[i*AW +: AW] != '0)) begin
                    rD[i*XLEN +: XLEN] = wD[j*XLEN +: XLEN];
                    rBusy[i] = issE && (issR == rR[i*AW +: AW]);
                end
            end
`endif
        end
    end

    assign pend = pend_q;

endmodule

// File: tb/tb_rf_multiport_sb.sv
// tb_rf_multiport_sb: table vectors, corner sequences and random traffic
// checked against an array-based register file / scoreboard model.
module tb_rf_multiport_sb;

    logic        clk;
    logic        reset;
    logic [9:0]  rR;
    logic [63:0] rD;
    logic [1:0]  rBusy;
    logic [1:0]  wE;
    logic [9:0]  wR;
    logic [63:0] wD;
    logic        issE;
    logic [4:0]  issR;
    logic [31:0] pend;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_pend;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  q0;
        logic [4:0]  q1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t tbl [8];

    rf_multiport_sb #(
        .XLEN(32), .NREG(32), .NRD(2), .NWR(2)
    ) dut (
        .clk(clk), .reset(reset), .rR(rR), .rD(rD), .rBusy(rBusy),
        .wE(wE), .wR(wR), .wD(wD), .issE(issE), .issR(issR), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_reg[k] = '0;
        m_pend = '0;
    endtask

    // Register file semantics at a rising edge.
    task automatic model_edge(input logic [1:0] we, input logic [4:0] a0,
                              input logic [31:0] d0, input logic [4:0] a1,
                              input logic [31:0] d1, input logic ie,
                              input logic [4:0] ir);
        if (we[0] && a0 != 0) m_reg[a0] = d0;
        if (we[1] && a1 != 0) m_reg[a1] = d1;
        if (we[0]) m_pend[a0] = 1'b0;
        if (we[1]) m_pend[a1] = 1'b0;
        if (ie && ir != 0) m_pend[ir] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    // Compare all outputs against the model for the current inputs.
    task automatic check_outs(input string tag);
        logic [4:0]  a;
        logic [31:0] e;
        logic        eb;
        for (int i = 0; i < 2; i++) begin
            a  = rR[i*5 +: 5];
            e  = (a == 0) ? 32'd0 : m_reg[a];
            eb = (a == 0) ? 1'b0 : m_pend[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < 2; j++) begin
                if (wE[j] && wR[j*5 +: 5] == a && a != 0) begin
                    e  = wD[j*32 +: 32];
                    eb = issE && (issR == a);
                end
            end
`endif
            chk($sformatf("%s rD%0d", tag, i), {32'd0, rD[i*32 +: 32]}, {32'd0, e});
            chk($sformatf("%s rBusy%0d", tag, i), {63'd0, rBusy[i]}, {63'd0, eb});
        end
        chk({tag, " pend"}, {32'd0, pend}, {32'd0, m_pend});
    endtask

    // One clock of stimulus: check before the edge, apply, check after.
    task automatic step(input logic [1:0] we, input logic [4:0] a0,
                        input logic [31:0] d0, input logic [4:0] a1,
                        input logic [31:0] d1, input logic ie,
                        input logic [4:0] ir, input logic [4:0] q0,
                        input logic [4:0] q1);
        wE = we; wR = {a1, a0}; wD = {d1, d0};
        issE = ie; issR = ir; rR = {q1, q0};
        #1;
        check_outs("pre");
        @(posedge clk);
        model_edge(we, a0, d0, a1, d1, ie, ir);
        #1;
        wE = '0; issE = 1'b0;
        #1;
        check_outs("post");
    endtask

    initial begin
        reset = 1'b0;
        rR = '0; wE = '0; wR = '0; wD = '0; issE = 1'b0; issR = '0;
        model_reset();

        // Reset held: every address reads zero even with writes/issues driven.
        for (int a = 0; a < 32; a++) begin
            rR = {5'(31 - a), 5'(a)};
            wE = 2'b11; wR = {5'(a), 5'(a)}; wD = {$urandom, $urandom};
            issE = 1'b1; issR = 5'(a);
            @(posedge clk);
            #2;
            chk("rst rD", rD, 64'd0);
            chk("rst rBusy", {62'd0, rBusy}, 64'd0);
            chk("rst pend", {32'd0, pend}, 64'd0);
        end
        wE = '0; issE = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #2;

        tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0,
                   5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00};
        tbl[1] = '{2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0,
                   5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 2'b00};
        tbl[2] = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0,
                   5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 2'b00};
        tbl[3] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3,
                   5'd3, 5'd7, 32'd0, 32'h22, 2'b01};
        tbl[4] = '{2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0,
                   5'd3, 5'd7, 32'h55, 32'h22, 2'b00};
        tbl[5] = '{2'b10, 5'd0, 32'd0, 5'd3, 32'h66, 1'b1, 5'd3,
                   5'd3, 5'd3, 32'h66, 32'h66, 2'b11};
        tbl[6] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0,
                   5'd0, 5'd3, 32'd0, 32'h66, 2'b10};
        tbl[7] = '{2'b10, 5'd0, 32'd0, 5'd8, 32'h88, 1'b0, 5'd0,
                   5'd8, 5'd3, 32'h88, 32'h66, 2'b10};

        for (int v = 0; v < 8; v++) begin
            step(tbl[v].we, tbl[v].r0, tbl[v].d0, tbl[v].r1, tbl[v].d1,
                 tbl[v].ie, tbl[v].ir, tbl[v].q0, tbl[v].q1);
            chk($sformatf("vec%0d rD0", v), {32'd0, rD[31:0]}, {32'd0, tbl[v].e0});
            chk($sformatf("vec%0d rD1", v), {32'd0, rD[63:32]}, {32'd0, tbl[v].e1});
            chk($sformatf("vec%0d rBusy", v), {62'd0, rBusy}, {62'd0, tbl[v].eb});
        end

        // Write-through window: x9 goes 0xA -> 0xB while being read.
        step(2'b01, 5'd9, 32'hA, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        wE = 2'b01; wR = {5'd0, 5'd9}; wD = {32'd0, 32'hB};
        issE = 1'b0; rR = {5'd0, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass same cycle", {32'd0, rD[31:0]}, 64'hB);
`else
        chk("no bypass same cycle", {32'd0, rD[31:0]}, 64'hA);
`endif
        @(posedge clk);
        model_edge(2'b01, 5'd9, 32'hB, 5'd0, 32'd0, 1'b0, 5'd0);
        #1 wE = '0;
        #1;
        chk("bypass next cycle", {32'd0, rD[31:0]}, 64'hB);

        // Mid-cycle async reset clears data and pending immediately.
        step(2'b01, 5'd4, 32'h77, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd9);
        step(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd9);
        chk("pre-async pend4", {63'd0, pend[4]}, 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async rD", rD, 64'd0);
        chk("async rBusy", {62'd0, rBusy}, 64'd0);
        chk("async pend", {32'd0, pend}, 64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #2;
        check_outs("after reset");

        // Random traffic on a narrow address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a0, a1, ir, q0, q1;
            a0 = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 7));
            ir = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
            q0 = ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom_range(0, 31));
            q1 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 7));
            step(2'($urandom), a0, $urandom, a1, $urandom,
                 1'($urandom), ir, q0, q1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
